// File: rtl/adc_cmd_transmitter.sv
// 8N1 serial command transmitter for an ADC, fed by a 16-byte circular FIFO.
// Frames go out back-to-back while the FIFO holds data; TxD idles high.
module adc_cmd_transmitter #(
    parameter int ClkFrequency  = 24000000,
    parameter int Baud          = 115200,
    parameter int FifoDepthLog2 = 4
) (
    input  logic       cclk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       TxD,
    output logic       TxD_busy,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int BitPeriod = ClkFrequency / Baud;
    localparam int BaudW     = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
    localparam int PtrW      = FifoDepthLog2;
    localparam int CntW      = FifoDepthLog2 + 1;
    localparam int Depth     = 1 << FifoDepthLog2;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BitPeriod - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, empty_q, overflow_q;
    logic            push, pop;

    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            baud_end;

    // A write into a full FIFO is dropped even when a pop frees a slot that cycle.
    assign push    = wr_en & ~full_q;
    assign count_d = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            if (wr_en && full_q) overflow_q <= 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge cclk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    assign baud_end = (baud_q == BaudLast);

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Register the next bit now so TxD changes exactly on the bit boundary.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign TxD      = txd_q;
    assign TxD_busy = (state_q != IDLE);
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_adc_cmd_transmitter.sv
// Scoreboard bench: written bytes are queued, a line monitor decodes each frame
// cycle-exactly and compares it against the queue head.
module tb_adc_cmd_transmitter;

    localparam int TbClkHz = 2400;
    localparam int TbBaud  = 100;
    localparam int BIT     = TbClkHz / TbBaud;   // 24 cycles per bit
    localparam int FRAME   = 10 * BIT;

    logic       cclk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       TxD, TxD_busy, full, empty, overflow;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    bit         watch_full = 1'b0;
    bit         saw_full;

    adc_cmd_transmitter #(
        .ClkFrequency (TbClkHz),
        .Baud         (TbBaud),
        .FifoDepthLog2(4)
    ) dut (
        .cclk    (cclk),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .TxD     (TxD),
        .TxD_busy(TxD_busy),
        .full    (full),
        .empty   (empty),
        .overflow(overflow)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) cyc <= cyc + 1;

    always @(negedge cclk) begin
        if (!watch_full) saw_full <= 1'b0;
        else if (full)   saw_full <= 1'b1;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accepted);
        @(posedge cclk); #1;
        wr_data = b;
        wr_en   = 1'b1;
        if (accepted) sb.push_back(b);
        @(posedge cclk); #1;
        wr_en = 1'b0;
    endtask

    task automatic measure_busy(output int n);
        n = 1;
        for (int i = 0; i < 30 * FRAME && TxD_busy; i++) begin
            @(posedge cclk); #1;
            if (TxD_busy) n++;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || TxD_busy || !empty) && n < limit) begin
            @(posedge cclk); #1;
            n++;
        end
        check({name, " drain"}, int'(sb.size() == 0 && !TxD_busy && empty), 1);
    endtask

    // Line monitor: every frame must be exactly BIT cycles per slot.
    initial begin : monitor
        logic [7:0] exp, got;
        logic       eb;
        bit         has_exp, bad, aborted;
        int         slot;
        forever begin
            @(negedge cclk);
            if (reset !== 1'b0 || TxD !== 1'b0) continue;
            if (sb.size() == 0) begin
                has_exp = 1'b0;
                exp     = 8'h00;
            end else begin
                has_exp = 1'b1;
                exp     = sb.pop_front();
            end
            bad     = 1'b0;
            aborted = 1'b0;
            got     = 8'h00;
            for (int idx = 0; idx < FRAME && !aborted; idx++) begin
                if (idx != 0) @(negedge cclk);
                if (reset) begin
                    aborted = 1'b1;
                end else begin
                    slot = idx / BIT;
                    eb = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : exp[slot-1];
                    if (TxD !== eb) bad = 1'b1;
                    if (slot >= 1 && slot <= 8 && (idx % BIT) == BIT / 2) got[slot-1] = TxD;
                end
            end
            if (!aborted) begin
                checks++;
                if (!has_exp || bad || got != exp) begin
                    errors++;
                    $display("FAIL frame: got %02h expected %02h (timing_ok=%0d expected_present=%0d)",
                             got, exp, !bad, has_exp);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n, cs;

        // Reset behaviour with no clock edge involved.
        #1 reset = 1'b1;
        #1;
        check("reset TxD", TxD, 1);
        check("reset busy", TxD_busy, 0);
        check("reset empty", empty, 1);
        check("reset full", full, 0);
        check("reset overflow", overflow, 0);
        repeat (3) @(posedge cclk);
        @(negedge cclk) reset = 1'b0;

        // Single byte: latency, frame length, final empty.
        write_byte(8'hA5, 1'b1);
        check("A5 TxD before pop", TxD, 1);
        check("A5 empty after write", empty, 0);
        @(posedge cclk); #1;
        check("A5 TxD start edge", TxD, 0);
        check("A5 busy", TxD_busy, 1);
        check("A5 empty after pop", empty, 1);
        measure_busy(n);
        check("A5 busy cycles", n, FRAME);
        check("A5 empty end", empty, 1);

        // Two consecutive writes -> two back-to-back frames.
        @(posedge cclk); #1;
        wr_data = 8'h01; wr_en = 1'b1; sb.push_back(8'h01);
        @(posedge cclk); #1;
        wr_data = 8'hFF; sb.push_back(8'hFF);
        @(posedge cclk); #1;
        wr_en = 1'b0;
        check("pair busy", TxD_busy, 1);
        measure_busy(n);
        check("pair busy cycles", n, 2 * FRAME);

        // Fill while busy: 16 accepted, 17th dropped.
        write_byte(8'h55, 1'b1);
        @(posedge cclk); #1;
        check("fill filler busy", TxD_busy, 1);
        for (int i = 0; i < 17; i++) begin
            write_byte(8'(i), i < 16);
            if (i == 14) check("fill full at 15", full, 0);
            if (i == 15) begin
                check("fill full at 16", full, 1);
                check("fill overflow at 16", overflow, 0);
            end
            if (i == 16) begin
                check("fill overflow at 17", overflow, 1);
                check("fill full at 17", full, 1);
            end
        end
        wait_idle("fill", 20 * FRAME);
        check("fill overflow sticky", overflow, 1);
        check("fill full end", full, 0);

        // Reset mid-frame aborts and discards queued bytes.
        write_byte(8'hC3, 1'b1);
        write_byte(8'h81, 1'b1);
        write_byte(8'h7E, 1'b1);
        repeat (100) @(posedge cclk);
        #1 reset = 1'b1;
        #1;
        check("abort TxD", TxD, 1);
        check("abort busy", TxD_busy, 0);
        check("abort empty", empty, 1);
        check("abort full", full, 0);
        check("abort overflow", overflow, 0);
        sb.delete();
        repeat (2) @(posedge cclk);
        @(negedge cclk);
        reset   = 1'b0;
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        sb.push_back(8'h3C);
        @(posedge cclk); #1;
        wr_en = 1'b0;
        check("post-reset write accepted", empty, 0);
        wait_idle("3C", 3 * FRAME);

        // Hold 15 bytes, then write in the same cycle as the frame-end pop.
        watch_full = 1'b1;
        write_byte(8'h99, 1'b1);
        @(posedge cclk); #1;
        cs = cyc;
        check("hold busy", TxD_busy, 1);
        for (int i = 0; i < 15; i++) write_byte(8'(8'h20 + i), 1'b1);
        check("hold full at 15", full, 0);
        n = 0;
        while (cyc != cs + FRAME - 1 && n < 2 * FRAME) begin
            @(posedge cclk); #1;
            n++;
        end
        check("hold align", cyc, cs + FRAME - 1);
        wr_data = 8'h2F;
        wr_en   = 1'b1;
        sb.push_back(8'h2F);
        @(posedge cclk); #1;
        wr_en = 1'b0;
        check("hold busy after pop", TxD_busy, 1);
        check("hold full after pop", full, 0);
        wait_idle("hold", 20 * FRAME);
        check("hold never full", saw_full, 0);

        // 40 bytes in bursts of 8: pointers wrap, order preserved.
        for (int burst = 0; burst < 5; burst++) begin
            for (int j = 0; j < 8; j++) write_byte(8'(((burst * 8 + j) * 29 + 7) & 8'hFF), 1'b1);
            wait_idle("wrap", 10 * FRAME);
        end
        check("wrap never full", saw_full, 0);
        watch_full = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
